// File: rtl/tx_stream_rx.sv
// Receive endpoint for the CPU's 7-bit character stream: frames messages on
// 7'h00 / 7'h7F and queues payload characters in a first-word-fall-through FIFO.
module tx_stream_rx #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [6:0]    rx,
  input  logic          clr,
  input  logic          rd_en,
  output logic [6:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          msg_active,
  output logic          msg_done,
  output logic          overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  state_t        state;
  logic [6:0]    rx_q;
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic is_open;
  logic is_close;
  logic is_payload;
  logic pop;
  logic push;
  logic drop;

  // Read side: rd_data is valid whenever empty is low; rd_en while empty is
  // ignored. A pop in the same cycle frees the slot a write needs when full.
  assign is_open    = (rx_q == 7'h00);
  assign is_close   = (rx_q == 7'h7F);
  assign is_payload = (state == RECV) && !is_open && !is_close;
  assign pop        = rd_en && !empty;
  assign push       = is_payload && (!full || pop);
  assign drop       = is_payload && full && !pop;

  assign empty      = (count == '0);
  assign full       = (count == FULL_COUNT);
  assign rd_data    = empty ? 7'h00 : mem[rd_ptr];
  assign msg_active = (state == RECV);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_q     <= 7'h7F;
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      msg_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rx_q <= rx;
      if (clr) begin
        state    <= IDLE;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        msg_done <= 1'b0;
        overflow <= 1'b0;
      end else begin
        msg_done <= 1'b0;
        case (state)
          IDLE: if (is_open) state <= RECV;
          RECV: begin
            if (is_close) begin
              state    <= IDLE;
              msg_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
        if (drop) overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= rx_q;
  end

endmodule

// File: doc/tx_stream_rx.md
Name: tx_stream_rx

Overview:
- Receive-side endpoint for the CPU's 7-bit parallel character output stream. One symbol arrives per clock.
- Framing on the stream:
  - 7'h00 opens a message.
  - 7'h7F closes a message and is also the idle level.
  - Any other value inside an open message is a payload character.
- Payload characters are captured into a first-word-fall-through (FWFT) FIFO, which a consumer (UART shim or checker) drains with a pop strobe.
- Message-boundary and overflow status are reported alongside the FIFO.

Parameters:
- DEPTH, 16, FIFO capacity in characters. Must be a power of two, at least 2.
- AW, $clog2(DEPTH), FIFO pointer width. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  7  character stream (connects to cpu tx).
- clr  input  1  synchronous flush: empties FIFO, clears overflow, returns FSM to IDLE.
- rd_en  input  1  pop strobe for the FIFO head.
- rd_data  output  7  FIFO head character; 7'h00 when empty.
- empty  output  1  FIFO holds no characters.
- full  output  1  FIFO holds DEPTH characters.
- count  output  AW+1  number of characters currently stored.
- msg_active  output  1  high while the FSM is in RECV.
- msg_done  output  1  one-cycle pulse when an open message is closed by 7'h7F.
- overflow  output  1  sticky; set when a payload character is dropped because the FIFO was full.

Behaviour:
- Reset (reset low, asynchronous):
  - rx_q = 7'h7F, FSM = IDLE, pointers = 0, count = 0.
  - empty = 1, full = 0, rd_data = 0, msg_active = 0, msg_done = 0, overflow = 0.
  - Reset asserted mid-message discards everything. Capture resumes only after a fresh 7'h00.
- Input stage: rx is registered into rx_q every cycle. The FSM and FIFO act on rx_q only.
- FSM in IDLE:
  - rx_q == 7'h00 -> RECV.
  - Any other value is ignored (no write, no status change).
- FSM in RECV, acting on rx_q:
  - 7'h00 -> stay in RECV (re-open). No write; FIFO contents are kept.
  - 7'h7F -> IDLE, and msg_done = 1 for exactly the following cycle.
  - Any other value:
    - If the FIFO is not full, or a pop happens in the same cycle, write the character.
    - Otherwise drop it and set overflow.
- Repeated identical characters on consecutive cycles are each a separate payload character; there is no de-duplication.
- Latency:
  - A character on rx before edge N reaches rx_q at edge N and is written at edge N+1.
  - After edge N+1, empty = 0 and rd_data shows the head (FWFT).
  - 7'h7F on rx before edge N gives msg_done high during the cycle after edge N+1.
- Read:
  - rd_en with empty = 0 pops the head at the edge.
  - rd_en with empty = 1 is ignored; count does not underflow and no error is raised.
- Simultaneous write and pop:
  - Both take effect and count is unchanged.
  - This holds when full: no drop, no overflow.
  - This holds when empty: the write happens and the pop is ignored, so count = 1.
- Pointer and flag arithmetic:
  - Pointers are AW bits and wrap modulo DEPTH.
  - count is an AW+1-bit true occupancy, range 0..DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- clr:
  - Has priority over write, pop and FSM transitions in its cycle.
  - Next state: pointers 0, count 0, overflow 0, IDLE, msg_done 0.
  - rx_q still samples normally during clr.
- overflow stays set until reset or clr, regardless of later pops.

Test Plan:
- Basic message: drive rx 7F,00,'H','i',7F,7F, pop while not empty.
  - Expect rd_data 'H' then 'i'.
  - Expect msg_done to pulse once, 2 cycles after 7F is driven.
  - Expect empty again and count = 0.
- Pre-start and idle filtering: drive 'X','Y' before any 7'h00, then 00,'A',7F.
  - Expect only 'A' stored.
  - Expect msg_active high exactly from the cycle after 00 reaches rx_q until 7F closes.
- Restart within a message: drive 00,'a',00,'b',7F.
  - Expect FIFO = 'a','b'.
  - Expect a single msg_done pulse and msg_active never dropping.
- Overflow with DEPTH=16:
  - Drive 00 then 18 characters 'A'..'R', no pops.
  - Expect full = 1, count = 16, contents 'A'..'P', overflow = 1.
  - Pop all: overflow stays 1 until clr.
  - Repeat with rd_en held high: expect no overflow.
- Reset mid-message: drive 00,'Q','R', then pulse reset low between clock edges.
  - Expect immediate empty = 1, msg_active = 0, count = 0.
  - Then drive 'S',7F: nothing stored and no msg_done.
- Wrap-around and clr:
  - Stream 40 characters in one message while popping every other cycle and checking order.
  - Assert clr for one cycle mid-message: expect flush and IDLE.
  - Following characters are ignored until the next 00.
